// File: rtl/arbitro_memoria_dados_if.sv
// Bus bundle for the data-memory arbiter: processor side, host handshake and memory side.
// "slave" is the arbiter's view; "master" is the surrounding system's view.
interface arbitro_memoria_dados_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_rd;
    logic              cpu_wr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              host_busy;
    logic              host_starved;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output cpu_rdata,
        output host_ack, host_rdata, host_busy, host_starved,
        output mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output cpu_addr, cpu_rd, cpu_wr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  cpu_rdata,
        input  host_ack, host_rdata, host_busy, host_starved,
        input  mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/arbitro_memoria_dados.sv
// Data-memory arbiter: the processor always owns the memory when it strobes; a latched
// host request runs in the first processor-idle cycle under a 4-phase req/ack handshake.
module arbitro_memoria_dados #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    arbitro_memoria_dados_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t            state;
    state_t            state_next;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [7:0]        wait_cnt;
    logic [7:0]        wait_cnt_inc;
    logic              starved;
    logic [DATA_W-1:0] rdata_q;
    logic              cpu_active;
    logic              host_go;

    assign cpu_active   = bus.cpu_rd | bus.cpu_wr;
    assign wait_cnt_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

    assign bus.cpu_rdata    = bus.mem_rdata;
    assign bus.host_ack     = (state == DONE);
    assign bus.host_busy    = (state == WAIT);
    assign bus.host_starved = starved;
    assign bus.host_rdata   = rdata_q;

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        state_next    = state;
        host_go       = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_wdata = '0;

        if (cpu_active) begin
            // A simultaneous read+write strobe is resolved as a write.
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wr    = bus.cpu_wr;
            bus.mem_rd    = bus.cpu_rd & ~bus.cpu_wr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (state == WAIT) begin
            host_go       = 1'b1;
            bus.mem_addr  = lat_addr;
            bus.mem_wr    = lat_we;
            bus.mem_rd    = ~lat_we;
            bus.mem_wdata = lat_wdata;
        end

        case (state)
            IDLE:    if (bus.host_req) state_next = WAIT;
            WAIT:    if (host_go)      state_next = DONE;
            DONE:    if (!bus.host_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
            starved   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.host_req) begin
                        lat_we    <= bus.host_we;
                        lat_addr  <= bus.host_addr;
                        lat_wdata <= bus.host_wdata;
                        wait_cnt  <= '0;
                    end
                end
                WAIT: begin
                    if (host_go) begin
                        starved <= 1'b0;
                        if (!lat_we) rdata_q <= bus.mem_rdata;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                        if (wait_cnt_inc >= MAX_WAIT_C) starved <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Directed bench for arbitro_memoria_dados: a vector table for the main flows plus
// hand-written sequences for illegal strobes, req drop in WAIT, reset mid-WAIT and back-to-back.
module tb_arbitro_memoria_dados;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    arbitro_memoria_dados_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    arbitro_memoria_dados #(.ADDR_W(8), .DATA_W(16), .MAX_WAIT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Single-port memory with asynchronous read, synchronous write.
    logic [15:0] mem [256];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        cr, cw;
        logic [7:0]  ca;
        logic [15:0] cwd;
        logic        hr, hw;
        logic [7:0]  ha;
        logic [15:0] hwd;
        logic        e_rd, e_wr;
        logic [7:0]  e_addr;
        logic [15:0] e_wdata;
        logic        e_ack, e_busy, e_st;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic cr, input logic cw, input logic [7:0] ca, input logic [15:0] cwd,
                        input logic hr, input logic hw, input logic [7:0] ha, input logic [15:0] hwd);
        @(negedge clk);
        bus.cpu_rd     = cr;
        bus.cpu_wr     = cw;
        bus.cpu_addr   = ca;
        bus.cpu_wdata  = cwd;
        bus.host_req   = hr;
        bus.host_we    = hw;
        bus.host_addr  = ha;
        bus.host_wdata = hwd;
        #1;
    endtask

    function automatic logic [31:0] host_view();
        return {13'd0, bus.host_ack, bus.host_busy, bus.host_starved, bus.host_rdata};
    endfunction

    function automatic logic [31:0] mem_view();
        return {6'd0, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        //         cr cw ca     cwd       hr hw ha     hwd       rd wr addr   wdata     ak by st rdata
        vecs.push_back(vec_t'{0, 0, 8'h00, 16'h0000, 1, 1, 8'h10, 16'h00A5, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 16'h0000});
        vecs.push_back(vec_t'{0, 0, 8'h00, 16'h0000, 1, 1, 8'h10, 16'h00A5, 0, 1, 8'h10, 16'h00A5, 0, 1, 0, 16'h0000});
        vecs.push_back(vec_t'{0, 0, 8'h00, 16'h0000, 1, 1, 8'h10, 16'h00A5, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 16'h0000});
        vecs.push_back(vec_t'{0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 16'h0000});
        vecs.push_back(vec_t'{0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 16'h0000});
        // Host read of 0x10 held off by five processor reads of 0x20; starvation after 3 waits.
        vecs.push_back(vec_t'{0, 0, 8'h00, 16'h0000, 1, 0, 8'h10, 16'hFFFF, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 16'h0000});
        vecs.push_back(vec_t'{1, 0, 8'h20, 16'h0000, 1, 1, 8'h33, 16'hDEAD, 1, 0, 8'h20, 16'h0000, 0, 1, 0, 16'h0000});
        vecs.push_back(vec_t'{1, 0, 8'h20, 16'h0000, 1, 1, 8'h33, 16'hDEAD, 1, 0, 8'h20, 16'h0000, 0, 1, 0, 16'h0000});
        vecs.push_back(vec_t'{1, 0, 8'h20, 16'h0000, 1, 1, 8'h33, 16'hDEAD, 1, 0, 8'h20, 16'h0000, 0, 1, 0, 16'h0000});
        vecs.push_back(vec_t'{1, 0, 8'h20, 16'h0000, 1, 1, 8'h33, 16'hDEAD, 1, 0, 8'h20, 16'h0000, 0, 1, 1, 16'h0000});
        vecs.push_back(vec_t'{1, 0, 8'h20, 16'h0000, 1, 1, 8'h33, 16'hDEAD, 1, 0, 8'h20, 16'h0000, 0, 1, 1, 16'h0000});
        vecs.push_back(vec_t'{0, 0, 8'h00, 16'h0000, 1, 1, 8'h33, 16'hDEAD, 1, 0, 8'h10, 16'hFFFF, 0, 1, 1, 16'h0000});
        vecs.push_back(vec_t'{0, 0, 8'h00, 16'h0000, 1, 1, 8'h33, 16'hDEAD, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 16'h00A5});
        vecs.push_back(vec_t'{0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 16'h00A5});
        vecs.push_back(vec_t'{0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 16'h00A5});
        // Host write behind two processor writes: one wait short of MAX_WAIT, no starvation.
        vecs.push_back(vec_t'{0, 0, 8'h00, 16'h0000, 1, 1, 8'h40, 16'h0BEE, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 16'h00A5});
        vecs.push_back(vec_t'{0, 1, 8'h41, 16'h1111, 1, 1, 8'h40, 16'h0BEE, 0, 1, 8'h41, 16'h1111, 0, 1, 0, 16'h00A5});
        vecs.push_back(vec_t'{0, 1, 8'h42, 16'h2222, 1, 1, 8'h40, 16'h0BEE, 0, 1, 8'h42, 16'h2222, 0, 1, 0, 16'h00A5});
        vecs.push_back(vec_t'{0, 0, 8'h00, 16'h0000, 1, 1, 8'h40, 16'h0BEE, 0, 1, 8'h40, 16'h0BEE, 0, 1, 0, 16'h00A5});
        vecs.push_back(vec_t'{0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 16'h00A5});
        vecs.push_back(vec_t'{0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 16'h00A5});

        // Reset state
        reset = 1'b1;
        step(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        step(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check("reset_host", host_view(), 32'h0);
        check("reset_mem", mem_view(), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cwd,
                 vecs[i].hr, vecs[i].hw, vecs[i].ha, vecs[i].hwd);
            check($sformatf("vec%0d_mem", i), mem_view(),
                  {6'd0, vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_addr, vecs[i].e_wdata});
            check($sformatf("vec%0d_host", i), host_view(),
                  {13'd0, vecs[i].e_ack, vecs[i].e_busy, vecs[i].e_st, vecs[i].e_rdata});
        end

        // Illegal read+write strobe resolves as a write
        step(1, 1, 8'h05, 16'h1234, 0, 0, 8'h00, 16'h0000);
        check("illegal_strobe_mem", mem_view(), {6'd0, 1'b0, 1'b1, 8'h05, 16'h1234});
        step(1, 0, 8'h05, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check("illegal_strobe_readback", 32'(bus.cpu_rdata), 32'h1234);

        // Host req dropped while in WAIT: access still completes, DONE exits on the next edge
        step(0, 0, 8'h00, 16'h0000, 1, 0, 8'h41, 16'h0000);
        check("drop_idle_busy", 32'(bus.host_busy), 32'h0);
        step(1, 0, 8'h42, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check("drop_wait_cpu", mem_view(), {6'd0, 1'b1, 1'b0, 8'h42, 16'h0000});
        check("drop_wait_busy", 32'(bus.host_busy), 32'h1);
        step(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check("drop_host_access", mem_view(), {6'd0, 1'b1, 1'b0, 8'h41, 16'h0000});
        step(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check("drop_done", host_view(), {13'd0, 3'b100, 16'h1111});
        step(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check("drop_idle_after", host_view(), {13'd0, 3'b000, 16'h1111});

        // Reset while a host write waits behind processor reads
        step(0, 0, 8'h00, 16'h0000, 1, 1, 8'h50, 16'h5555);
        step(1, 0, 8'h20, 16'h0000, 1, 1, 8'h50, 16'h5555);
        check("rst_pending_busy", 32'(bus.host_busy), 32'h1);
        step(1, 0, 8'h20, 16'h0000, 1, 1, 8'h50, 16'h5555);
        reset = 1'b1;
        #1;
        check("rst_asserted_host", host_view(), 32'h0);
        step(1, 0, 8'h50, 16'h0000, 1, 1, 8'h50, 16'h5555);
        check("rst_no_host_write", 32'(bus.cpu_rdata), 32'h0);
        check("rst_held_mem", mem_view(), {6'd0, 1'b1, 1'b0, 8'h50, 16'h0000});
        @(negedge clk);
        reset = 1'b0;
        bus.cpu_rd = 1'b0;
        #1;
        check("rst_release_mem", mem_view(), 32'h0);
        step(0, 0, 8'h00, 16'h0000, 1, 1, 8'h50, 16'h5555);
        check("rst_recapture_write", mem_view(), {6'd0, 1'b0, 1'b1, 8'h50, 16'h5555});
        step(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check("rst_recapture_ack", 32'(bus.host_ack), 32'h1);
        step(1, 0, 8'h50, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check("rst_recapture_data", 32'(bus.cpu_rdata), 32'h5555);

        // Back-to-back: read 0x10, then a write raised the cycle after ack falls
        step(0, 0, 8'h00, 16'h0000, 1, 0, 8'h10, 16'h0000);
        step(0, 0, 8'h00, 16'h0000, 1, 0, 8'h10, 16'h0000);
        check("b2b_read_access", mem_view(), {6'd0, 1'b1, 1'b0, 8'h10, 16'h0000});
        step(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check("b2b_read_done", host_view(), {13'd0, 3'b100, 16'h00A5});
        step(0, 0, 8'h00, 16'h0000, 1, 1, 8'h60, 16'hC0DE);
        check("b2b_second_idle", host_view(), {13'd0, 3'b000, 16'h00A5});
        step(0, 0, 8'h00, 16'h0000, 1, 1, 8'h60, 16'hC0DE);
        check("b2b_write_access", mem_view(), {6'd0, 1'b0, 1'b1, 8'h60, 16'hC0DE});
        step(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check("b2b_write_done", host_view(), {13'd0, 3'b100, 16'h00A5});
        step(1, 0, 8'h60, 16'h0000, 0, 0, 8'h00, 16'h0000);
        check("b2b_write_data", 32'(bus.cpu_rdata), 32'hC0DE);
        check("b2b_final_host", host_view(), {13'd0, 3'b000, 16'h00A5});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
